// File: rtl/memory_stage.sv
// memory_stage: registers ALU results for writeback and performs LDD/STD
// accesses to a local word-addressed data memory with a fixed number of
// wait cycles, stalling upstream while an access is in flight.
module memory_stage #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [3:0]  ex_func,
  input  logic [15:0] ex_alu_out,
  input  logic [15:0] ex_store_data,
  input  logic [2:0]  ex_rdst,
  input  logic [2:0]  ex_flags,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [15:0] wb_data,
  output logic [2:0]  wb_rdst,
  output logic [2:0]  wb_flags
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [3:0]  LAT   = 4'(MEM_LATENCY);

  localparam logic [3:0] F_LDD = 4'b0001;
  localparam logic [3:0] F_STD = 4'b0010;
  localparam logic [3:0] F_ADD = 4'b0011;
  localparam logic [3:0] F_NOT = 4'b0100;
  localparam logic [3:0] F_NOP = 4'b0101;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         sdata_q, sdata_d;
  logic                is_ld_q, is_ld_d;
  logic [2:0]          prdst_q, prdst_d;
  logic [2:0]          pflags_q, pflags_d;
  logic                stall_q, stall_d;
  logic                wbv_q, wbv_d;
  logic                wbwe_q, wbwe_d;
  logic [15:0]         wbdata_q, wbdata_d;
  logic [2:0]          wbrdst_q, wbrdst_d;
  logic [2:0]          wbflags_q, wbflags_d;
  logic                mem_we;
  logic [15:0]         rd_data;
  logic [15:0]         mem [DEPTH];

  // Address bits above ADDR_W are intentionally ignored (addresses alias).
  logic unused_alu_hi;
  assign unused_alu_hi = ^ex_alu_out;

  assign rd_data = mem[addr_q];

  // Pipeline and FSM state registers; memory contents are deliberately not reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      sdata_q   <= '0;
      is_ld_q   <= 1'b0;
      prdst_q   <= '0;
      pflags_q  <= '0;
      stall_q   <= 1'b0;
      wbv_q     <= 1'b0;
      wbwe_q    <= 1'b0;
      wbdata_q  <= '0;
      wbrdst_q  <= '0;
      wbflags_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      sdata_q   <= sdata_d;
      is_ld_q   <= is_ld_d;
      prdst_q   <= prdst_d;
      pflags_q  <= pflags_d;
      stall_q   <= stall_d;
      wbv_q     <= wbv_d;
      wbwe_q    <= wbwe_d;
      wbdata_q  <= wbdata_d;
      wbrdst_q  <= wbrdst_d;
      wbflags_q <= wbflags_d;
    end
  end

  // Accept in IDLE, count down wait cycles, retire on the count==1 edge.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    sdata_d   = sdata_q;
    is_ld_d   = is_ld_q;
    prdst_d   = prdst_q;
    pflags_d  = pflags_q;
    stall_d   = stall_q;
    wbv_d     = 1'b0;
    wbwe_d    = 1'b0;
    wbdata_d  = wbdata_q;
    wbrdst_d  = wbrdst_q;
    wbflags_d = wbflags_q;
    mem_we    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ex_valid) begin
          case (ex_func)
            F_ADD, F_NOT: begin
              wbv_d     = 1'b1;
              wbwe_d    = 1'b1;
              wbdata_d  = ex_alu_out;
              wbrdst_d  = ex_rdst;
              wbflags_d = ex_flags;
            end
            F_LDD, F_STD: begin
              addr_d   = ex_alu_out[ADDR_W-1:0];
              sdata_d  = ex_store_data;
              is_ld_d  = (ex_func == F_LDD);
              prdst_d  = ex_rdst;
              pflags_d = ex_flags;
              cnt_d    = LAT;
              stall_d  = 1'b1;
              state_d  = S_WAIT;
            end
            F_NOP:   ;
            default: ;
          endcase
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          stall_d   = 1'b0;
          wbv_d     = 1'b1;
          wbrdst_d  = prdst_q;
          wbflags_d = pflags_q;
          if (is_ld_q) begin
            wbwe_d   = 1'b1;
            wbdata_d = rd_data;
          end else begin
            mem_we = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Store commit happens on the retiring edge only.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= sdata_q;
  end

  assign mem_stall = stall_q;
  assign wb_valid  = wbv_q;
  assign wb_we     = wbwe_q;
  assign wb_data   = wbdata_q;
  assign wb_rdst   = wbrdst_q;
  assign wb_flags  = wbflags_q;

endmodule

// File: tb/tb_memory_stage.sv
// Testbench for memory_stage: directed scenarios plus randomized traffic
// checked against a behavioural model (word array + last-retired values).
module tb_memory_stage;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned LAT    = 2;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  localparam logic [3:0] F_LDD = 4'b0001;
  localparam logic [3:0] F_STD = 4'b0010;
  localparam logic [3:0] F_ADD = 4'b0011;
  localparam logic [3:0] F_NOT = 4'b0100;
  localparam logic [3:0] F_NOP = 4'b0101;

  logic        clk = 1'b0;
  logic        clk_en = 1'b1;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0;
  logic [3:0]  ex_func = '0;
  logic [15:0] ex_alu_out = '0;
  logic [15:0] ex_store_data = '0;
  logic [2:0]  ex_rdst = '0;
  logic [2:0]  ex_flags = '0;
  logic        mem_stall, wb_valid, wb_we;
  logic [15:0] wb_data;
  logic [2:0]  wb_rdst, wb_flags;

  int checks = 0;
  int failures = 0;

  // Reference model: memory image and the values writeback should hold.
  logic [15:0] model_mem [DEPTH];
  bit          known [DEPTH];
  logic [15:0] exp_data = '0;
  logic [2:0]  exp_rdst = '0;
  logic [2:0]  exp_flags = '0;

  memory_stage #(.ADDR_W(ADDR_W), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_func(ex_func),
    .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data), .ex_rdst(ex_rdst),
    .ex_flags(ex_flags), .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_we(wb_we),
    .wb_data(wb_data), .wb_rdst(wb_rdst), .wb_flags(wb_flags)
  );

  always #5 if (clk_en) clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] f, input logic [15:0] a, sd,
                       input logic [2:0] r, fl);
    @(negedge clk);
    ex_valid = v; ex_func = f; ex_alu_out = a; ex_store_data = sd; ex_rdst = r; ex_flags = fl;
  endtask

  // One single-cycle (non-memory) instruction, checked one edge after accept.
  task automatic test_alu_op(input logic [3:0] f, input logic [15:0] a, input logic [2:0] r, fl,
                             input string tag);
    bit writes;
    writes = (f == F_ADD) || (f == F_NOT);
    drive(1'b1, f, a, 16'h0, r, fl);
    tick();
    if (writes) begin
      exp_data = a; exp_rdst = r; exp_flags = fl;
    end
    checks++;
    if (wb_valid !== writes) begin
      failures++; $display("FAIL %s wb_valid: got %b expected %b", tag, wb_valid, writes);
    end
    checks++;
    if (wb_we !== writes) begin
      failures++; $display("FAIL %s wb_we: got %b expected %b", tag, wb_we, writes);
    end
    checks++;
    if (mem_stall !== 1'b0) begin
      failures++; $display("FAIL %s mem_stall: got %b expected 0", tag, mem_stall);
    end
    checks++;
    if (wb_data !== exp_data) begin
      failures++; $display("FAIL %s wb_data: got %h expected %h", tag, wb_data, exp_data);
    end
    checks++;
    if (wb_rdst !== exp_rdst || wb_flags !== exp_flags) begin
      failures++;
      $display("FAIL %s rdst/flags: got %0d/%b expected %0d/%b", tag, wb_rdst, wb_flags,
               exp_rdst, exp_flags);
    end
  endtask

  // One LDD/STD: measure stall length and retire latency, then check retirement.
  task automatic test_mem_access(input bit is_ld, input logic [15:0] a, sd,
                                 input logic [2:0] r, fl, input bit scramble, input string tag);
    logic [ADDR_W-1:0] idx;
    int unsigned n, stalls;
    idx = ADDR_W'(a % DEPTH);
    n = 0; stalls = 0;
    drive(1'b1, is_ld ? F_LDD : F_STD, a, sd, r, fl);
    tick();
    while (wb_valid !== 1'b1 && n < LAT + 4) begin
      if (mem_stall === 1'b1) stalls++;
      @(negedge clk);
      if (scramble) begin
        ex_valid = 1'b1; ex_func = 4'($urandom_range(0, 15)); ex_alu_out = 16'($urandom);
        ex_store_data = 16'($urandom); ex_rdst = 3'($urandom); ex_flags = 3'($urandom);
      end else begin
        ex_valid = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    if (is_ld) exp_data = model_mem[idx];
    else begin
      model_mem[idx] = sd; known[idx] = 1'b1;
    end
    exp_rdst = r; exp_flags = fl;
    checks++;
    if (n != LAT) begin
      failures++; $display("FAIL %s retire_latency: got %0d expected %0d", tag, n, LAT);
    end
    checks++;
    if (stalls != LAT) begin
      failures++; $display("FAIL %s stall_cycles: got %0d expected %0d", tag, stalls, LAT);
    end
    checks++;
    if (wb_valid !== 1'b1 || mem_stall !== 1'b0) begin
      failures++; $display("FAIL %s retire valid/stall: got %b/%b expected 1/0", tag, wb_valid, mem_stall);
    end
    checks++;
    if (wb_we !== is_ld) begin
      failures++; $display("FAIL %s wb_we: got %b expected %b", tag, wb_we, is_ld);
    end
    checks++;
    if (wb_data !== exp_data) begin
      failures++; $display("FAIL %s wb_data: got %h expected %h", tag, wb_data, exp_data);
    end
    checks++;
    if (wb_rdst !== exp_rdst || wb_flags !== exp_flags) begin
      failures++;
      $display("FAIL %s rdst/flags: got %0d/%b expected %0d/%b", tag, wb_rdst, wb_flags,
               exp_rdst, exp_flags);
    end
    ex_valid = 1'b0;
  endtask

  task automatic test_reset();
    tick(); tick();
    checks++;
    if ({mem_stall, wb_valid, wb_we, wb_data, wb_rdst, wb_flags} !== '0) begin
      failures++; $display("FAIL reset_initial outputs: got %h expected 0",
                           {mem_stall, wb_valid, wb_we, wb_data, wb_rdst, wb_flags});
    end
    @(negedge clk); reset = 1'b0;
    test_alu_op(F_ADD, 16'hFFFF, 3'd7, 3'b111, "pre_reset_add");
    @(negedge clk);
    clk_en = 1'b0;
    #2; reset = 1'b1; ex_valid = 1'b0;
    #1;
    checks++;
    if ({mem_stall, wb_valid, wb_we, wb_data, wb_rdst, wb_flags} !== '0) begin
      failures++; $display("FAIL reset_async outputs: got %h expected 0",
                           {mem_stall, wb_valid, wb_we, wb_data, wb_rdst, wb_flags});
    end
    #2; reset = 1'b0;
    exp_data = '0; exp_rdst = '0; exp_flags = '0;
    #1; clk_en = 1'b1;
  endtask

  task automatic test_alu();
    test_alu_op(F_ADD, 16'h1234, 3'd5, 3'b000, "add_1234");
    drive(1'b0, F_ADD, 16'h9999, 16'h0, 3'd1, 3'b001);
    tick();
    checks++;
    if (wb_valid !== 1'b0 || wb_we !== 1'b0 || wb_data !== exp_data) begin
      failures++; $display("FAIL idle_after_add: got v=%b we=%b d=%h expected v=0 we=0 d=%h",
                           wb_valid, wb_we, wb_data, exp_data);
    end
    test_alu_op(F_NOT, 16'hEDCB, 3'd2, 3'b010, "not_edcb");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      test_alu_op((i % 2 == 0) ? F_ADD : F_NOT, 16'($urandom), 3'($urandom), 3'($urandom), "b2b_alu");
  endtask

  task automatic test_nop_bubble();
    int pulses;
    pulses = 0;
    test_alu_op(F_NOP, 16'h7777, 3'd4, 3'b100, "nop_0101");
    pulses += int'(wb_valid);
    test_alu_op(4'b1111, 16'h6666, 3'd6, 3'b110, "undef_1111");
    pulses += int'(wb_valid);
    test_alu_op(F_ADD, 16'h0001, 3'd1, 3'b001, "add_after_nops");
    pulses += int'(wb_valid);
    checks++;
    if (pulses != 1) begin
      failures++; $display("FAIL nop_pulse_count: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_mem_raw();
    test_mem_access(1'b0, 16'h0010, 16'hBEEF, 3'd2, 3'b101, 1'b0, "std_0010");
    test_mem_access(1'b1, 16'h0010, 16'h0000, 3'd3, 3'b010, 1'b0, "ldd_0010");
  endtask

  task automatic test_alias();
    test_mem_access(1'b0, 16'h03FF, 16'hAAAA, 3'd1, 3'b000, 1'b0, "std_03ff");
    test_mem_access(1'b1, 16'h07FF, 16'h0000, 3'd4, 3'b001, 1'b0, "ldd_07ff");
    test_mem_access(1'b0, 16'h0400, 16'h5555, 3'd2, 3'b011, 1'b0, "std_0400");
    test_mem_access(1'b1, 16'h0000, 16'h0000, 3'd5, 3'b100, 1'b0, "ldd_0000");
  endtask

  task automatic test_stall_ignore();
    test_mem_access(1'b0, 16'h0030, 16'h1357, 3'd1, 3'b001, 1'b1, "std_scrambled");
    test_mem_access(1'b1, 16'h8030, 16'h0000, 3'd6, 3'b110, 1'b1, "ldd_scrambled");
    drive(1'b0, F_NOP, 16'h0, 16'h0, 3'd0, 3'd0);
    tick();
    checks++;
    if (wb_valid !== 1'b0) begin
      failures++; $display("FAIL stall_extra_pulse: got %b expected 0", wb_valid);
    end
  endtask

  task automatic test_reset_abort();
    test_mem_access(1'b0, 16'h0020, 16'h0000, 3'd4, 3'b000, 1'b0, "preload_0020");
    drive(1'b1, F_STD, 16'h0020, 16'h1111, 3'd6, 3'b111);
    tick();
    ex_valid = 1'b0;
    for (int i = 1; i < int'(LAT); i++) tick();
    @(negedge clk); reset = 1'b1;
    #1;
    checks++;
    if (mem_stall !== 1'b0 || wb_valid !== 1'b0) begin
      failures++; $display("FAIL abort_in_reset stall/valid: got %b/%b expected 0/0", mem_stall, wb_valid);
    end
    tick();
    @(negedge clk); reset = 1'b0;
    exp_data = '0; exp_rdst = '0; exp_flags = '0;
    tick();
    checks++;
    if (mem_stall !== 1'b0 || wb_valid !== 1'b0 || wb_data !== 16'h0000) begin
      failures++; $display("FAIL abort_after_reset stall/valid/data: got %b/%b/%h expected 0/0/0000",
                           mem_stall, wb_valid, wb_data);
    end
    test_mem_access(1'b1, 16'h0020, 16'h0000, 3'd2, 3'b000, 1'b0, "ldd_after_abort");
  endtask

  task automatic test_random();
    logic [15:0] a;
    int unsigned k;
    for (int i = 0; i < 16; i++)
      test_mem_access(1'b0, {6'($urandom), 6'b0, 4'(i)}, 16'($urandom), 3'($urandom), 3'($urandom),
                      1'($urandom), "rand_prefill");
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 5);
      a = {6'($urandom), 6'b0, 4'($urandom_range(0, 15))};
      case (k)
        0: test_alu_op(F_ADD, 16'($urandom), 3'($urandom), 3'($urandom), "rand_add");
        1: test_alu_op(F_NOT, 16'($urandom), 3'($urandom), 3'($urandom), "rand_not");
        2: test_alu_op(F_NOP, 16'($urandom), 3'($urandom), 3'($urandom), "rand_nop");
        3: test_alu_op(4'($urandom_range(6, 15)), 16'($urandom), 3'($urandom), 3'($urandom), "rand_undef");
        4: test_mem_access(1'b0, a, 16'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), "rand_std");
        default: test_mem_access(1'b1, a, 16'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), "rand_ldd");
      endcase
    end
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      model_mem[i] = '0; known[i] = 1'b0;
    end
    test_reset();
    test_alu();
    test_back_to_back();
    test_nop_bubble();
    test_mem_raw();
    test_alias();
    test_stall_ignore();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
Pipeline stage directly downstream of the execute ALU. It registers the ALU result, ALU flags and destination register, and performs LDD/STD accesses to a local word-addressed data memory with a configurable wait-state count. It stalls the upstream stages while an access is in flight and presents one retired result per instruction to writeback.

Parameters:
ADDR_W, 10, data memory address width; depth is 2^ADDR_W 16-bit words
MEM_LATENCY, 2, wait cycles per LDD/STD access; legal range 1..15

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
ex_valid  in  1  execute stage presents an instruction
ex_func  in  4  function code: 0001 LDD, 0010 STD, 0011 ADD, 0100 NOT, 0101 NOP; others treated as NOP
ex_alu_out  in  16  ALU result; effective address for LDD/STD
ex_store_data  in  16  data to write for STD
ex_rdst  in  3  destination register index
ex_flags  in  3  {carry, negative, zero} from ALU
mem_stall  out  1  high while an access is in flight; upstream must hold its outputs
wb_valid  out  1  one-cycle pulse per retired non-NOP instruction
wb_we  out  1  register-file write enable, qualified by wb_valid
wb_data  out  16  ALU result or loaded word
wb_rdst  out  3  destination register index
wb_flags  out  3  captured ALU flags

Behaviour:
- Reset asynchronous, active-high: state IDLE, wait counter 0, all outputs 0. Memory contents are not reset. Reset during WAIT aborts the access; a pending STD is not committed.
- FSM states: IDLE, WAIT.
- Accept: rising edge with ex_valid=1 and state IDLE. Inputs are ignored in WAIT.
- ADD/NOT accepted at edge N:
  - After edge N: wb_valid=1, wb_we=1, wb_data=ex_alu_out, wb_rdst and wb_flags captured. Latency 1.
- NOP or undefined code accepted at edge N:
  - After edge N: wb_valid=0, wb_we=0. The bubble is consumed and other wb_* outputs hold their previous values.
- LDD/STD accepted at edge N:
  - Capture addr=ex_alu_out[ADDR_W-1:0]; bits above are ignored, so addresses alias modulo depth.
  - Capture store data, rdst and flags.
  - Go to WAIT with counter=MEM_LATENCY. mem_stall=1 is a registered output, high from edge N to edge N+MEM_LATENCY.
  - Counter decrements each edge in WAIT. At the edge where counter==1, the instruction retires and the FSM returns to IDLE:
    - LDD: wb_data=mem[addr], wb_we=1.
    - STD: mem[addr]=store data written at this edge; wb_we=0 and wb_data holds.
  - Both set wb_valid=1 for one cycle.
- No accept occurs on the retiring edge. The next instruction is accepted at edge N+MEM_LATENCY+1 at the earliest. Throughput is 1 per cycle for ALU ops and 1 per MEM_LATENCY+1 cycles for memory ops.
- wb_valid is deasserted on every edge that does not retire an instruction.
- Read-after-write: an LDD following an STD to the same address returns the stored data, because the write commits before the LDD can be accepted.

Test Plan:
- Assert reset mid-cycle with clk stopped -> all outputs 0 immediately. Release reset, then ADD with ex_alu_out=0x1234, rdst=5, flags=000 -> after the next edge wb_valid=1, wb_we=1, wb_data=0x1234, wb_rdst=5. After one further edge wb_valid=0.
- With MEM_LATENCY=2, STD addr 0x0010 data 0xBEEF, then LDD addr 0x0010 rdst=3 -> mem_stall high for 2 cycles each. The STD retire shows wb_valid=1, wb_we=0. The LDD retire shows wb_data=0xBEEF, wb_we=1.
- Wrap/alias: STD to 0x03FF with 0xAAAA, then LDD 0x07FF (ADDR_W=10) -> returns 0xAAAA. STD 0x0400 with 0x5555 -> LDD 0x0000 returns 0x5555.
- During mem_stall, change ex_func/ex_alu_out every cycle -> the retired result reflects only the originally accepted instruction, and no extra wb_valid pulses appear.
- NOP (0101) and code 1111 back-to-back with ADD 0x0001 -> exactly one wb_valid pulse (for the ADD), with no stall.
- STD 0x0020 data 0x1111, then reset asserted on the cycle before retire -> after reset, LDD 0x0020 does not return 0x1111 (pre-loaded 0x0000 is unchanged). After reset, mem_stall=0 and wb_valid=0.
